// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator register: default width and the
// resolved per-cycle operation type.
package ac_pkg;

  localparam int AC_WORD_SIZE = 24;

  typedef enum logic [2:0] {
    OP_RESET,
    OP_LOAD_ALU,
    OP_LOAD_BUS,
    OP_INC,
    OP_HOLD
  } ac_op_t;

endpackage

// File: rtl/ac_op_select.sv
// Fixed-priority resolution of the AC control lines into a single operation.
import ac_pkg::*;

module ac_op_select (
  input  logic   rst,
  input  logic   alu_to_ac,
  input  logic   write_en,
  input  logic   incre,
  output ac_op_t op
);

  // Controls never combine: the first active line in this order wins.
  always_comb begin
    op = OP_HOLD;
    if (rst)            op = OP_RESET;
    else if (alu_to_ac) op = OP_LOAD_ALU;
    else if (write_en)  op = OP_LOAD_BUS;
    else if (incre)     op = OP_INC;
  end

endmodule

// File: rtl/ac_register.sv
// Accumulator register: one word, reloaded from bus/ALU, incremented, cleared
// or held each cycle; the register drives data_out directly.
import ac_pkg::*;

module ac_register #(
  parameter int WORD_SIZE = AC_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic                 alu_to_ac,
  input  logic                 incre,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic [WORD_SIZE-1:0] data_out
);

  ac_op_t               op;
  logic [WORD_SIZE-1:0] ac, ac_nxt;

  ac_op_select u_op_select (
    .rst       (rst),
    .alu_to_ac (alu_to_ac),
    .write_en  (write_en),
    .incre     (incre),
    .op        (op)
  );

  // Increment wraps naturally at the register width.
  always_comb begin
    ac_nxt = ac;
    case (op)
      OP_RESET:    ac_nxt = '0;
      OP_LOAD_ALU: ac_nxt = alu_out;
      OP_LOAD_BUS: ac_nxt = data_in;
      OP_INC:      ac_nxt = ac + WORD_SIZE'(1);
      default:     ac_nxt = ac;
    endcase
  end

  always_ff @(posedge clk) ac <= ac_nxt;

  assign data_out = ac;

`ifndef SYNTHESIS
  a_rst_clears: assert property (@(posedge clk) rst |=> data_out == '0)
    else $error("ac_register: data_out not cleared after rst");

  // Any change must coincide with clk being high, i.e. follow a rising edge.
  always @(data_out) begin
    if ($time > 0)
      a_edge_only: assert (clk === 1'b1)
        else $error("ac_register: data_out changed away from rising edge");
  end
`endif

endmodule

// File: tb/tb_ac_register.sv
// Directed plus random bench for ac_register with a queue-based scoreboard.
module tb_ac_register;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         write_en = 1'b0;
  logic         alu_to_ac = 1'b0;
  logic         incre = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] alu_out = '0;
  logic [W-1:0] data_out;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mdl = '0;

  ac_register #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .write_en  (write_en),
    .alu_to_ac (alu_to_ac),
    .incre     (incre),
    .data_in   (data_in),
    .alu_out   (alu_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur,
      input logic r, input logic a, input logic w, input logic i,
      input logic [W-1:0] din, input logic [W-1:0] aout);
    if (r)      return '0;
    else if (a) return aout;
    else if (w) return din;
    else if (i) return cur + 1;
    else        return cur;
  endfunction

  // Drive one cycle of controls just after an edge, check nothing moves before
  // the next edge, then check the registered result just after it.
  task automatic step(input string tag, input logic r, input logic a,
      input logic w, input logic i, input logic [W-1:0] din,
      input logic [W-1:0] aout, input logic [W-1:0] exp);
    logic [W-1:0] prev, want;
    prev = data_out;
    rst = r; alu_to_ac = a; write_en = w; incre = i;
    data_in = din; alu_out = aout;
    exp_q.push_back(exp);
    #1;
    total++;
    assert (data_out === prev) else begin
      bad++;
      $error("FAIL %s_early got=%h exp=%h", tag, data_out, prev);
    end
    @(posedge clk); #1;
    want = exp_q.pop_front();
    total++;
    assert (data_out === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, data_out, want);
    end
    mdl = want;
  endtask

  initial begin
    logic         r, a, w, i;
    logic [W-1:0] din, aout, e;
    @(posedge clk); #1;

    step("reset",       1, 0, 1, 0, 24'd20, 24'd0, 24'd0);
    step("bus_load",    0, 0, 1, 0, 24'd20, 24'd0, 24'd20);
    step("alu_prio",    0, 1, 1, 0, 24'd20, 24'd64, 24'd64);
    step("load_after",  0, 0, 1, 0, 24'd43, 24'd64, 24'd43);
    for (int k = 0; k < 3; k++)
      step("hold",      0, 0, 0, 0, 24'd99, 24'd77, 24'd43);
    step("load_fffffe", 0, 0, 1, 0, 24'hFFFFFE, 24'd0, 24'hFFFFFE);
    step("inc_ffffff",  0, 0, 0, 1, 24'd0, 24'd0, 24'hFFFFFF);
    step("inc_wrap",    0, 0, 0, 1, 24'd0, 24'd0, 24'h000000);
    step("inc_one",     0, 0, 0, 1, 24'd0, 24'd0, 24'h000001);
    step("bus_over_inc",0, 0, 1, 1, 24'd5, 24'd0, 24'd5);
    step("mid_reset",   1, 1, 0, 0, 24'd0, 24'hABCDEF, 24'd0);
    step("post_reset",  0, 1, 0, 0, 24'd0, 24'hABCDEF, 24'hABCDEF);
    step("inc_repeat",  0, 0, 0, 1, 24'd0, 24'd0, 24'hABCDF0);

    for (int k = 0; k < 32; k++) begin
      r    = ($urandom_range(0, 11) == 0);
      a    = ($urandom_range(0, 3) == 0);
      w    = ($urandom_range(0, 2) == 0);
      i    = $urandom_range(0, 1) == 1;
      din  = W'($urandom);
      aout = W'($urandom);
      if (k == 5) din = '1;
      e = ref_next(mdl, r, a, w, i, din, aout);
      step("rand", r, a, w, i, din, aout, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
